// File: rtl/alu_result_accum.sv
// Sums COUNT consecutive ALU results into one total with a sticky carry flag
// and hands it downstream over a valid/ready handshake.
module alu_result_accum #(
  parameter int DATA_W = 32,
  parameter int COUNT  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_i_W,
  input  logic              io_i_valid,
  output logic              io_o_ready,
  input  logic              io_i_clear,
  output logic [DATA_W-1:0] io_o_sum,
  output logic              io_o_ovf,
  output logic              io_o_valid,
  input  logic              io_i_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_e            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic [DATA_W-1:0] sum_q;
  logic              sum_ovf_q;
  logic              valid_q;

  logic [DATA_W:0]   add_res;
  logic [DATA_W-1:0] acc_d;
  logic              ovf_d;
  logic              in_acc;
  logic              out_acc;
  logic              last_in;

  function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always_comb begin
    add_res = add_carry(acc_q, io_i_W);
    acc_d   = add_res[DATA_W-1:0];
    ovf_d   = ovf_q | add_res[DATA_W];
  end

  // Ready is gated by reset and clear so nothing is taken while either is active.
  assign io_o_ready = reset & ~io_i_clear & (state_q == ACCUM);
  assign in_acc     = io_i_valid & io_o_ready;
  assign out_acc    = valid_q & io_i_ready;
  assign last_in    = (cnt_q == LAST_CNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (io_i_clear) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_acc) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_in) begin
              sum_q     <= acc_d;
              sum_ovf_q <= ovf_d;
              valid_q   <= 1'b1;
              state_q   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_acc) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_o_sum   = sum_q;
  assign io_o_ovf   = sum_ovf_q;
  assign io_o_valid = valid_q;

endmodule
